lcd_init_seq: RTL

// - Parametrised HD44780 power-on initialisation sequencer; successor to the fixed 4-bit init block.
// - Bus width (4/8), line count, font and display/entry modes are generics.
// - Adds a built-in power-up wait, a self-contained E-strobe engine, a start/busy/done handshake and a re-init request.
// - Sits between the top-level controller and the LCD pins. The character writer takes the bus after `done`.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_strobe.sv | 103 ++++++++++
 rtl/lcd_init_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared state types, HD44780 opcodes and timing constants for the LCD init sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_RAW,
    S_CMD,
    S_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    STB_IDLE,
    STB_SETUP,
    STB_HIGH,
    STB_HOLD,
    STB_DELAY
  } stb_state_e;

  localparam logic [7:0] OP_FUNC_SET = 8'h20;
  localparam logic [7:0] OP_DISP_OFF = 8'h08;
  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_ENTRY    = 8'h04;
  localparam logic [7:0] OP_DISP_ON  = 8'h0C;

  // Raw wake-up writes carry only an upper nibble.
  localparam logic [7:0] RAW_WAKE    = 8'h30;
  localparam logic [7:0] RAW_4BIT    = 8'h20;

  localparam int unsigned T_PHASE_US = 1;
  localparam int unsigned T_GAP_US   = 1;
  localparam int unsigned T_WAKE1_US = 4100;
  localparam int unsigned T_WAKE_US  = 100;
  localparam int unsigned T_CMD_US   = 53;
  localparam int unsigned T_CLR_US   = 2000;

  // Rounds up to whole cycles and never returns 0, so a counter load of n-1 is always valid.
  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_hz);
    longint unsigned c;
    c = (64'(us) * 64'(clk_hz) + 64'd999_999) / 64'd1_000_000;
    if (c == 64'd0) c = 64'd1;
    return 32'(c);
  endfunction

endpackage

// File: rtl/lcd_strobe.sv
// One LCD write: setup, E high, hold, then a caller-supplied step delay ending in a one-cycle fin.
module lcd_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DLY_W       = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [7:0]       data,
  input  logic [DLY_W-1:0] delay_cycles,
  output logic [7:0]       lcd_d,
  output logic             lcd_e,
  output logic             fin
);

  localparam int unsigned      PH_CYC  = us_to_cycles(T_PHASE_US, CLK_FREQ_HZ);
  localparam logic [DLY_W-1:0] PH_LOAD = DLY_W'(PH_CYC - 1);

  stb_state_e       st_q, st_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]       data_q, data_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q   <= STB_IDLE;
      cnt_q  <= '0;
      dly_q  <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dly_q  <= dly_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    dly_d  = dly_q;
    data_d = data_q;
    fin    = 1'b0;
    case (st_q)
      STB_IDLE: begin
        if (go) begin
          st_d   = STB_SETUP;
          cnt_d  = PH_LOAD;
          data_d = data;
          dly_d  = delay_cycles;
        end
      end
      STB_SETUP: begin
        if (cnt_q == '0) begin
          st_d  = STB_HIGH;
          cnt_d = PH_LOAD;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      STB_HIGH: begin
        if (cnt_q == '0) begin
          st_d  = STB_HOLD;
          cnt_d = PH_LOAD;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      STB_HOLD: begin
        if (cnt_q == '0) begin
          st_d  = STB_DELAY;
          cnt_d = dly_q - DLY_W'(1);
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      STB_DELAY: begin
        if (cnt_q == '0) begin
          fin = 1'b1;
          // A go in the fin cycle chains the next write with no idle cycle in between.
          if (go) begin
            st_d   = STB_SETUP;
            cnt_d  = PH_LOAD;
            data_d = data;
            dly_d  = delay_cycles;
          end else begin
            st_d   = STB_IDLE;
            data_d = '0;
          end
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      default: st_d = STB_IDLE;
    endcase
  end

  assign lcd_d = data_q;
  assign lcd_e = (st_q == STB_HIGH);

endmodule

// File: rtl/lcd_init_seq.sv
// HD44780 power-on initialisation sequencer: power-up wait, raw wake-up writes, then configuration bytes.
//   state   | meaning
//   IDLE    | waiting for start, bus parked at 0
//   PWRUP   | power-up wait before the first write
//   RAW     | 0x3 wake-up nibbles (plus 0x2 in 4-bit mode)
//   CMD     | function set, display off, clear, entry mode, display on
//   DONE    | sequence complete, bus handed over; start re-runs everything
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BUS_WIDTH   = 4,
  parameter bit          TWO_LINES   = 1'b1,
  parameter bit          FONT_5X10   = 1'b0,
  parameter bit          CURSOR_ON   = 1'b0,
  parameter bit          BLINK_ON    = 1'b0,
  parameter bit          ENTRY_INC   = 1'b1,
  parameter bit          ENTRY_SHIFT = 1'b0,
  parameter int unsigned T_PWRUP_US  = 15000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] LCD_D,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E
);

  if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_bus_width
    $error("lcd_init_seq: BUS_WIDTH must be 4 or 8");
  end

  localparam bit          IS_8BIT   = (BUS_WIDTH == 8);
  localparam int unsigned DLY_W     = $clog2(us_to_cycles(T_WAKE1_US, CLK_FREQ_HZ) + 1);
  localparam int unsigned PW_CYC    = us_to_cycles(T_PWRUP_US, CLK_FREQ_HZ);
  localparam int unsigned PW_W      = $clog2(PW_CYC + 1);
  localparam int unsigned RAW_STEPS = IS_8BIT ? 3 : 4;
  localparam int unsigned NUM_STEPS = IS_8BIT ? 8 : 14;

  localparam logic [PW_W-1:0] PW_LOAD   = PW_W'(PW_CYC - 1);
  localparam logic [3:0]      LAST_STEP = 4'(NUM_STEPS - 1);
  localparam logic [3:0]      FIRST_CMD = 4'(RAW_STEPS);

  localparam logic [DLY_W-1:0] D_WAKE1 = DLY_W'(us_to_cycles(T_WAKE1_US, CLK_FREQ_HZ));
  localparam logic [DLY_W-1:0] D_WAKE  = DLY_W'(us_to_cycles(T_WAKE_US, CLK_FREQ_HZ));
  localparam logic [DLY_W-1:0] D_CMD   = DLY_W'(us_to_cycles(T_CMD_US, CLK_FREQ_HZ));
  localparam logic [DLY_W-1:0] D_CLR   = DLY_W'(us_to_cycles(T_CLR_US, CLK_FREQ_HZ));
  localparam logic [DLY_W-1:0] D_GAP   = DLY_W'(us_to_cycles(T_GAP_US, CLK_FREQ_HZ));

  localparam logic [7:0] FS_BYTE  = OP_FUNC_SET | {3'b000, IS_8BIT, TWO_LINES, FONT_5X10, 2'b00};
  localparam logic [7:0] EM_BYTE  = OP_ENTRY | {6'b000000, ENTRY_INC, ENTRY_SHIFT};
  localparam logic [7:0] DON_BYTE = OP_DISP_ON | {6'b000000, CURSOR_ON, BLINK_ON};

  seq_state_e       state_q, state_d;
  logic [PW_W-1:0]  pw_cnt_q, pw_cnt_d;
  logic [3:0]       step_q, step_d;
  logic             stb_go, stb_fin, stb_e;
  logic [7:0]       stb_d;
  logic [7:0]       rom_data;
  logic [DLY_W-1:0] rom_dly;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      pw_cnt_q <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      pw_cnt_q <= pw_cnt_d;
      step_q   <= step_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pw_cnt_d = pw_cnt_q;
    step_d   = step_q;
    stb_go   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_PWRUP;
          pw_cnt_d = PW_LOAD;
          step_d   = '0;
        end
      end
      S_PWRUP: begin
        if (pw_cnt_q == '0) begin
          state_d = S_RAW;
          step_d  = '0;
          stb_go  = 1'b1;
        end else begin
          pw_cnt_d = pw_cnt_q - PW_W'(1);
        end
      end
      S_RAW, S_CMD: begin
        if (stb_fin) begin
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
            step_d  = '0;
          end else begin
            step_d  = step_q + 4'd1;
            stb_go  = 1'b1;
            state_d = (step_d < FIRST_CMD) ? S_RAW : S_CMD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Step ROM indexed by the step being launched; 4-bit bytes split into high nibble + gap, low nibble + delay.
  always_comb begin
    rom_data = 8'h00;
    rom_dly  = D_CMD;
    if (IS_8BIT) begin
      case (step_d)
        4'd0:       begin rom_data = RAW_WAKE;    rom_dly = D_WAKE1; end
        4'd1, 4'd2: begin rom_data = RAW_WAKE;    rom_dly = D_WAKE;  end
        4'd3:       begin rom_data = FS_BYTE;     rom_dly = D_CMD;   end
        4'd4:       begin rom_data = OP_DISP_OFF; rom_dly = D_CMD;   end
        4'd5:       begin rom_data = OP_CLEAR;    rom_dly = D_CLR;   end
        4'd6:       begin rom_data = EM_BYTE;     rom_dly = D_CMD;   end
        4'd7:       begin rom_data = DON_BYTE;    rom_dly = D_CMD;   end
        default:    begin rom_data = 8'h00;       rom_dly = D_CMD;   end
      endcase
    end else begin
      case (step_d)
        4'd0:       begin rom_data = RAW_WAKE;                    rom_dly = D_WAKE1; end
        4'd1, 4'd2: begin rom_data = RAW_WAKE;                    rom_dly = D_WAKE;  end
        4'd3:       begin rom_data = RAW_4BIT;                    rom_dly = D_WAKE;  end
        4'd4:       begin rom_data = {FS_BYTE[7:4], 4'h0};        rom_dly = D_GAP;   end
        4'd5:       begin rom_data = {FS_BYTE[3:0], 4'h0};        rom_dly = D_CMD;   end
        4'd6:       begin rom_data = {OP_DISP_OFF[7:4], 4'h0};    rom_dly = D_GAP;   end
        4'd7:       begin rom_data = {OP_DISP_OFF[3:0], 4'h0};    rom_dly = D_CMD;   end
        4'd8:       begin rom_data = {OP_CLEAR[7:4], 4'h0};       rom_dly = D_GAP;   end
        4'd9:       begin rom_data = {OP_CLEAR[3:0], 4'h0};       rom_dly = D_CLR;   end
        4'd10:      begin rom_data = {EM_BYTE[7:4], 4'h0};        rom_dly = D_GAP;   end
        4'd11:      begin rom_data = {EM_BYTE[3:0], 4'h0};        rom_dly = D_CMD;   end
        4'd12:      begin rom_data = {DON_BYTE[7:4], 4'h0};       rom_dly = D_GAP;   end
        4'd13:      begin rom_data = {DON_BYTE[3:0], 4'h0};       rom_dly = D_CMD;   end
        default:    begin rom_data = 8'h00;                       rom_dly = D_CMD;   end
      endcase
    end
  end

  lcd_strobe #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .DLY_W       (DLY_W)
  ) u_strobe (
    .clk          (CLK),
    .reset_n      (RESET_N),
    .go           (stb_go),
    .data         (rom_data),
    .delay_cycles (rom_dly),
    .lcd_d        (stb_d),
    .lcd_e        (stb_e),
    .fin          (stb_fin)
  );

  assign busy   = (state_q == S_PWRUP) || (state_q == S_RAW) || (state_q == S_CMD);
  assign done   = (state_q == S_DONE);
  assign LCD_D  = ((state_q == S_RAW) || (state_q == S_CMD)) ? stb_d : 8'h00;
  assign LCD_E  = stb_e;
  assign LCD_RS = 1'b0;
  assign LCD_RW = 1'b0;

endmodule
